// File: rtl/global_load_sequencer_pkg.sv
// Shared types and defaults for the global BRAM load sequencer.
// Imported by the interface and the sequencer module.
package global_load_sequencer_pkg;

    localparam int GLS_DATA_W = 128;
    localparam int GLS_ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CLOSE   = 3'd2,
        OVERLAP = 3'd3,
        RUN     = 3'd4
    } gls_state_t;

endpackage

// File: rtl/global_load_sequencer_if.sv
// Command, stream and BRAM load-port bundle of the load sequencer.
// master = host/accelerator side, slave = sequencer side.
interface global_load_sequencer_if
    import global_load_sequencer_pkg::*;
#(
    parameter int DATA_W = GLS_DATA_W,
    parameter int ADDR_W = GLS_ADDR_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr;
    logic [31:0]       cmd_num_words;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic [ADDR_W-1:0] wr_addr_global_initial;
    logic [DATA_W-1:0] data_load_in_global;
    logic              we_global_initial;
    logic              load_phase;
    logic              start;
    logic              compute_done;

    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_words,
        output s_valid, s_data, compute_done,
        input  cmd_ready, s_ready,
        input  wr_addr_global_initial, data_load_in_global,
        input  we_global_initial, load_phase, start,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_words,
        input  s_valid, s_data, compute_done,
        output cmd_ready, s_ready,
        output wr_addr_global_initial, data_load_in_global,
        output we_global_initial, load_phase, start,
        output busy, done
    );

endinterface

// File: rtl/global_load_sequencer.sv
// Streams N words into global BRAM, closes the load window,
// then holds start until the accelerator reports completion.
module global_load_sequencer
    import global_load_sequencer_pkg::*;
#(
    parameter int DATA_W        = GLS_DATA_W,
    parameter int ADDR_W        = GLS_ADDR_W,
    parameter int START_OVERLAP = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    global_load_sequencer_if.slave  bus
);

    localparam int OVL_W = $clog2(START_OVERLAP + 1);
    localparam logic [OVL_W-1:0] OVL_LAST = OVL_W'(START_OVERLAP);
    localparam logic [OVL_W-1:0] OVL_ONE  = OVL_W'(1);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_LOAD    = LOAD;
    localparam logic [2:0] S_CLOSE   = CLOSE;
    localparam logic [2:0] S_OVERLAP = OVERLAP;
    localparam logic [2:0] S_RUN     = RUN;

    logic [2:0]        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       count_q;
    logic [31:0]       idx_q;
    logic [31:0]       idx_inc;
    logic [OVL_W-1:0]  ovl_q;

    logic              cmd_ready_q;
    logic              s_ready_q;
    logic              we_q;
    logic              load_phase_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              beat;

    assign beat    = s_ready_q & bus.s_valid;
    assign idx_inc = idx_q + 32'd1;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            ovl_q        <= '0;
            cmd_ready_q  <= 1'b1;
            s_ready_q    <= 1'b0;
            we_q         <= 1'b0;
            load_phase_q <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        base_q       <= bus.cmd_base_addr;
                        count_q      <= bus.cmd_num_words;
                        idx_q        <= '0;
                        load_phase_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cmd_ready_q  <= 1'b0;
                        s_ready_q    <= (bus.cmd_num_words != 32'd0);
                        state_q      <= (bus.cmd_num_words == 32'd0)
                                        ? S_CLOSE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Leave only once the last write cycle has
                    // been presented, so CLOSE is a clean gap.
                    if (beat) begin
                        we_q      <= 1'b1;
                        addr_q    <= base_q + ADDR_W'(idx_q);
                        data_q    <= bus.s_data;
                        idx_q     <= idx_inc;
                        s_ready_q <= (idx_inc < count_q);
                    end else if (idx_q == count_q) begin
                        state_q <= S_CLOSE;
                    end
                end
                S_CLOSE: begin
                    start_q <= 1'b1;
                    ovl_q   <= OVL_ONE;
                    state_q <= S_OVERLAP;
                end
                S_OVERLAP: begin
                    if (ovl_q == OVL_LAST) begin
                        load_phase_q <= 1'b0;
                        state_q      <= S_RUN;
                    end else begin
                        ovl_q <= ovl_q + OVL_ONE;
                    end
                end
                S_RUN: begin
                    if (bus.compute_done) begin
                        start_q     <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    cmd_ready_q  <= 1'b1;
                    s_ready_q    <= 1'b0;
                    load_phase_q <= 1'b0;
                    start_q      <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready              = cmd_ready_q;
    assign bus.s_ready                = s_ready_q;
    assign bus.wr_addr_global_initial = addr_q;
    assign bus.data_load_in_global    = data_q;
    assign bus.we_global_initial      = we_q;
    assign bus.load_phase             = load_phase_q;
    assign bus.start                  = start_q;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;

endmodule
